// File: rtl/sram_sp_init_mask.sv
// Single-port SRAM with per-lane write mask, registered read port and a hardware init sweep.
// Define SRAM_OUTREG_EN to add a second output register stage (read latency 2).
module sram_sp_init_mask #(
  parameter int unsigned    BW       = 12,
  parameter int unsigned    NUM      = 1024,
  parameter int unsigned    IDX_BITS = 10,
  parameter int unsigned    LANE_BW  = 4,
  parameter logic [BW-1:0]  INIT_VAL = '0
) (
  input  logic                    CLK,
  input  logic                    RSTN,
  input  logic                    CEN,
  input  logic                    WEN,
  input  logic [IDX_BITS-1:0]     A,
  input  logic [BW-1:0]           D,
  input  logic [BW/LANE_BW-1:0]   WM,
  input  logic                    INIT_REQ,
  output logic [BW-1:0]           Q,
  output logic                    Q_VALID,
  output logic                    BUSY
);

  localparam int unsigned NLANE = BW / LANE_BW;
  localparam logic [IDX_BITS-1:0] LAST_IDX = IDX_BITS'(NUM - 1);

  typedef enum logic {StInit, StReady} state_e;

  state_e              r_state, w_state_nxt;
  logic [IDX_BITS-1:0] r_cnt, w_cnt_nxt;
  logic [BW-1:0]       r_mem [NUM];
  logic [BW-1:0]       r_q;
  logic                r_q_valid;

  logic                w_in_range;
  logic                w_rd;
  logic                w_wr;
  logic                w_init_wr;
  logic [BW-1:0]       w_rdata;

  // NUM need not be a power of two, so addresses above the array are decoded out.
  assign w_in_range = ({1'b0, A} < (IDX_BITS + 1)'(NUM));
  assign w_rdata    = w_in_range ? r_mem[A] : '0;

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      r_state <= StInit;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_rd        = 1'b0;
    w_wr        = 1'b0;
    w_init_wr   = 1'b0;
    unique case (r_state)
      StInit: begin
        w_init_wr = 1'b1;
        w_cnt_nxt = r_cnt + IDX_BITS'(1);
        if (r_cnt == LAST_IDX) begin
          w_state_nxt = StReady;
          w_cnt_nxt   = '0;
        end
      end
      StReady: begin
        // A sweep request wins over any access issued in the same cycle.
        if (INIT_REQ) begin
          w_state_nxt = StInit;
          w_cnt_nxt   = '0;
        end else if (!CEN) begin
          w_rd = WEN;
          w_wr = !WEN && w_in_range;
        end
      end
      default: begin
        w_state_nxt = StInit;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (w_init_wr) begin
      r_mem[r_cnt] <= INIT_VAL;
    end else if (w_wr) begin
      for (int n = 0; n < NLANE; n++) begin
        if (WM[n]) begin
          r_mem[A][n*LANE_BW +: LANE_BW] <= D[n*LANE_BW +: LANE_BW];
        end
      end
    end
  end

`ifdef SRAM_OUTREG_EN
  logic [BW-1:0] r_s1_q;
  logic          r_s1_valid;
  logic          w_flush;
  logic          w_s1_adv;

  // Entering the sweep drops the read still sitting in the first stage.
  assign w_flush  = (r_state == StReady) && INIT_REQ;
  assign w_s1_adv = r_s1_valid && !w_flush;

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      r_s1_q     <= '0;
      r_s1_valid <= 1'b0;
      r_q        <= '0;
      r_q_valid  <= 1'b0;
    end else begin
      r_s1_valid <= w_rd;
      if (w_rd) begin
        r_s1_q <= w_rdata;
      end
      r_q_valid <= w_s1_adv;
      if (w_s1_adv) begin
        r_q <= r_s1_q;
      end
    end
  end
`else
  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      r_q       <= '0;
      r_q_valid <= 1'b0;
    end else begin
      r_q_valid <= w_rd;
      if (w_rd) begin
        r_q <= w_rdata;
      end
    end
  end
`endif

  assign Q       = r_q;
  assign Q_VALID = r_q_valid;
  assign BUSY    = (r_state == StInit);

endmodule

// File: tb/tb_sram_sp_init_mask.sv
// Directed self-checking bench for sram_sp_init_mask (default parameters).
// Follows SRAM_OUTREG_EN for the expected read latency.
module tb_sram_sp_init_mask;

`ifdef SRAM_OUTREG_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  logic        CLK = 1'b0;
  logic        RSTN;
  logic        CEN;
  logic        WEN;
  logic [9:0]  A;
  logic [11:0] D;
  logic [2:0]  WM;
  logic        INIT_REQ;
  logic [11:0] Q;
  logic        Q_VALID;
  logic        BUSY;

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [11:0] exp3 [3];

  sram_sp_init_mask dut (
    .CLK      (CLK),
    .RSTN     (RSTN),
    .CEN      (CEN),
    .WEN      (WEN),
    .A        (A),
    .D        (D),
    .WM       (WM),
    .INIT_REQ (INIT_REQ),
    .Q        (Q),
    .Q_VALID  (Q_VALID),
    .BUSY     (BUSY)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic idle();
    CEN      = 1'b1;
    WEN      = 1'b1;
    INIT_REQ = 1'b0;
    A        = '0;
    D        = '0;
    WM       = '0;
  endtask

  // Counts BUSY cycles until READY; inputs are left as the caller set them.
  task automatic wait_sweep(input string tag);
    int n = 0;
    int v = 0;
    while (BUSY && n < 3000) begin
      n++;
      if (Q_VALID) v++;
      tick();
    end
    check({tag, "_busy_cycles"}, n, 1024);
    check({tag, "_no_valid"}, v, 0);
  endtask

  task automatic wr(input logic [9:0] addr, input logic [11:0] data, input logic [2:0] mask);
    CEN = 1'b0; WEN = 1'b0; A = addr; D = data; WM = mask;
    tick();
    idle();
    check("wr_no_valid", Q_VALID, 0);
  endtask

  task automatic rd(input string tag, input logic [9:0] addr, input logic [11:0] exp);
    CEN = 1'b0; WEN = 1'b1; A = addr;
    tick();
    idle();
    repeat (LAT - 1) tick();
    check({tag, "_valid"}, Q_VALID, 1);
    check({tag, "_q"}, Q, exp);
    tick();
    check({tag, "_valid_drop"}, Q_VALID, 0);
    check({tag, "_q_hold"}, Q, exp);
  endtask

  initial begin
    exp3[0] = 12'h011;
    exp3[1] = 12'h022;
    exp3[2] = 12'h033;
    idle();
    RSTN = 1'b0;
    repeat (3) tick();
    check("rst_q", Q, 0);
    check("rst_valid", Q_VALID, 0);
    check("rst_busy", BUSY, 1);

    // A write held throughout the power-on sweep must be ignored.
    CEN = 1'b0; WEN = 1'b0; A = 10'd9; D = 12'h555; WM = 3'b111;
    RSTN = 1'b1;
    wait_sweep("sweep0");
    idle();
    rd("rd_a5", 10'd5, 12'h000);
    rd("rd_a9_busy_wr", 10'd9, 12'h000);

    wr(10'd7, 12'hABC, 3'b111);
    rd("rd_a7_full", 10'd7, 12'hABC);
    wr(10'd7, 12'h123, 3'b010);
    rd("rd_a7_mask", 10'd7, 12'hA2C);
    wr(10'd7, 12'hFFF, 3'b000);
    rd("rd_a7_nomask", 10'd7, 12'hA2C);

    wr(10'd1, 12'h011, 3'b111);
    wr(10'd2, 12'h022, 3'b111);
    wr(10'd3, 12'h033, 3'b111);
    for (int i = 0; i < 3 + LAT; i++) begin
      if (i < 3) begin
        CEN = 1'b0; WEN = 1'b1; A = 10'(i + 1);
      end else begin
        idle();
      end
      tick();
      if (i >= LAT - 1 && i - LAT + 1 < 3) begin
        check("b2b_valid", Q_VALID, 1);
        check("b2b_q", Q, exp3[i-LAT+1]);
      end
    end
    check("b2b_valid_end", Q_VALID, 0);

    // Read in flight plus a read in the request cycle: both must be dropped by the sweep.
    CEN = 1'b0; WEN = 1'b1; A = 10'd3;
    tick();
    INIT_REQ = 1'b1;
    tick();
    INIT_REQ = 1'b0;
    check("req_busy", BUSY, 1);
    wait_sweep("sweep_req");
    idle();
    check("req_q_hold", Q, 12'h033);
    rd("rd_a7_after_req", 10'd7, 12'h000);
    rd("rd_a3_after_req", 10'd3, 12'h000);

    // INIT_REQ held high: one READY cycle between sweeps.
    INIT_REQ = 1'b1;
    tick();
    check("rep_busy", BUSY, 1);
    wait_sweep("sweep_rep1");
    check("rep_gap_busy", BUSY, 0);
    tick();
    check("rep_restart_busy", BUSY, 1);
    INIT_REQ = 1'b0;
    wait_sweep("sweep_rep2");
    idle();

    // Reset while a read result is on Q.
    wr(10'd4, 12'h444, 3'b111);
    CEN = 1'b0; WEN = 1'b1; A = 10'd4;
    repeat (LAT) tick();
    idle();
    check("pre_rst_valid", Q_VALID, 1);
    check("pre_rst_q", Q, 12'h444);
    #2 RSTN = 1'b0;
    #1;
    check("rst_rd_q", Q, 0);
    check("rst_rd_valid", Q_VALID, 0);
    check("rst_rd_busy", BUSY, 1);
    tick();
    RSTN = 1'b1;
    wait_sweep("sweep_rst_rd");
    idle();

    // Reset at sweep cycle 300.
    wr(10'd4, 12'h444, 3'b111);
    rd("rd_a4", 10'd4, 12'h444);
    INIT_REQ = 1'b1;
    tick();
    INIT_REQ = 1'b0;
    repeat (300) tick();
    check("mid_busy", BUSY, 1);
    check("mid_q_hold", Q, 12'h444);
    #2 RSTN = 1'b0;
    #1;
    check("rst_mid_q", Q, 0);
    check("rst_mid_valid", Q_VALID, 0);
    tick();
    RSTN = 1'b1;
    wait_sweep("sweep_rst_mid");
    idle();
    rd("rd_a4_after_rst", 10'd4, 12'h000);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
